// File: rtl/ped_pkg.sv
// Shared types and helpers for the pedestrian request unit.
package ped_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SERVING = 2'd2,
        LOCKOUT = 2'd3
    } ped_state_e;

    // Largest value a width-bit unsigned counter can hold.
    function automatic logic [31:0] sat_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/buton_debouncer.sv
// Conditions the raw push-button: 2-FF synchronizer, debounce filter, rising-edge pulse.
module buton_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic raw_i,
    output logic stable_o,
    output logic press_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_r;
    logic          s2_r;
    logic          stable_r;
    logic          stable_d_r;
    logic [CW-1:0] cnt_r;

    // Synchronize, then flip the stable level only after enough consecutive disagreements.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s1_r       <= 1'b0;
            s2_r       <= 1'b0;
            stable_r   <= 1'b0;
            stable_d_r <= 1'b0;
            cnt_r      <= '0;
        end else begin
            s1_r       <= raw_i;
            s2_r       <= s1_r;
            stable_d_r <= stable_r;
            if (s2_r != stable_r) begin
                if (cnt_r == CNT_LAST) begin
                    stable_r <= s2_r;
                    cnt_r    <= '0;
                end else begin
                    cnt_r <= cnt_r + CW'(1);
                end
            end else begin
                cnt_r <= '0;
            end
        end
    end

    assign stable_o = stable_r;
    assign press_o  = stable_r & ~stable_d_r;

endmodule

// File: rtl/pedestrian_request_unit.sv
// Latches a debounced pedestrian request until the walk phase serves it, then
// holds off new presses for a lockout window and counts accepted requests.
module pedestrian_request_unit
    import ped_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCKOUT_CYCLES  = 8,
    parameter int CNT_W           = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             service_i,
    input  logic             buton_i,
    input  logic             verde_pietoni_i,
    output logic             cerere_o,
    output logic             asteptare_o,
    output logic [CNT_W-1:0] press_count_o
);
    localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [LW-1:0]    LOCK_LOAD  = LW'((LOCKOUT_CYCLES > 0) ? LOCKOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(sat_max(CNT_W));
    localparam bit               NO_LOCKOUT = (LOCKOUT_CYCLES == 32'sd0);

    logic             press_s;
    logic             stable_unused_s;
    ped_state_e       state_r;
    ped_state_e       state_nx_s;
    logic [LW-1:0]    lock_r;
    logic [LW-1:0]    lock_nx_s;
    logic             count_inc_s;
    logic [CNT_W-1:0] count_r;
    logic             cerere_r;
    logic             asteptare_r;

    buton_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .raw_i    (buton_i),
        .stable_o (stable_unused_s),
        .press_o  (press_s)
    );

    // Next-state logic; service beats disable, which beats the walk signal, which beats a press.
    always_comb begin
        state_nx_s  = state_r;
        lock_nx_s   = lock_r;
        count_inc_s = 1'b0;
        if (service_i) begin
            state_nx_s = IDLE;
            lock_nx_s  = '0;
        end else if (!enable_i) begin
            state_nx_s = state_r;
            lock_nx_s  = lock_r;
        end else begin
            case (state_r)
                IDLE: begin
                    if (verde_pietoni_i) begin
                        state_nx_s = SERVING;
                    end else if (press_s) begin
                        state_nx_s  = PENDING;
                        count_inc_s = 1'b1;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                PENDING: begin
                    if (verde_pietoni_i) begin
                        state_nx_s = SERVING;
                    end else begin
                        state_nx_s = PENDING;
                    end
                end
                SERVING: begin
                    if (verde_pietoni_i) begin
                        state_nx_s = SERVING;
                    end else if (NO_LOCKOUT) begin
                        state_nx_s = IDLE;
                    end else begin
                        state_nx_s = LOCKOUT;
                        lock_nx_s  = LOCK_LOAD;
                    end
                end
                LOCKOUT: begin
                    if (verde_pietoni_i) begin
                        state_nx_s = SERVING;
                    end else if (lock_r == '0) begin
                        state_nx_s = IDLE;
                    end else begin
                        lock_nx_s = lock_r - LW'(1);
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                    lock_nx_s  = '0;
                end
            endcase
        end
    end

    // State, lockout timer, saturating press counter and the request/wait lamps.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r     <= IDLE;
            lock_r      <= '0;
            count_r     <= '0;
            cerere_r    <= 1'b0;
            asteptare_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            lock_r      <= lock_nx_s;
            cerere_r    <= (state_nx_s == PENDING);
            asteptare_r <= (state_nx_s == PENDING);
            if (count_inc_s && (count_r != CNT_MAX)) begin
                count_r <= count_r + CNT_W'(1);
            end else begin
                count_r <= count_r;
            end
        end
    end

    assign cerere_o      = cerere_r;
    assign asteptare_o   = asteptare_r;
    assign press_count_o = count_r;

endmodule

// File: tb/tb_pedestrian_request_unit.sv
// Directed and randomized checks of pedestrian_request_unit against a behavioural model.
module tb_pedestrian_request_unit;
    localparam int DEB  = 4;
    localparam int LOCK = 8;
    localparam int MAX  = 255;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       svc;
    logic       btn;
    logic       verde;
    logic       cer;
    logic       ast;
    logic [7:0] cnt;

    int total = 0;
    int bad   = 0;

    pedestrian_request_unit #(
        .DEBOUNCE_CYCLES (DEB),
        .LOCKOUT_CYCLES  (LOCK),
        .CNT_W           (8)
    ) dut (
        .clk_i           (clk),
        .reset_i         (rst),
        .enable_i        (en),
        .service_i       (svc),
        .buton_i         (btn),
        .verde_pietoni_i (verde),
        .cerere_o        (cer),
        .asteptare_o     (ast),
        .press_count_o   (cnt)
    );

    always #5 clk = ~clk;

    // Model: hist[i] is the button sample taken i+1 edges ago.
    bit hist [0:DEB];
    bit m_stab;
    bit m_stab_d;
    bit m_pend;
    bit m_walk;
    int m_lock;
    int m_count;

    task automatic model_step();
        bit press;
        bit flip;
        if (rst) begin
            for (int i = 0; i <= DEB; i++) hist[i] = 1'b0;
            m_stab = 1'b0; m_stab_d = 1'b0; m_pend = 1'b0; m_walk = 1'b0;
            m_lock = 0; m_count = 0;
        end else begin
            press = m_stab && !m_stab_d;
            if (svc) begin
                m_pend = 1'b0; m_walk = 1'b0; m_lock = 0;
            end else if (en) begin
                if (verde) begin
                    m_pend = 1'b0; m_walk = 1'b1; m_lock = 0;
                end else if (m_walk) begin
                    m_walk = 1'b0; m_lock = LOCK;
                end else if (m_lock > 0) begin
                    m_lock = m_lock - 1;
                end else if (!m_pend && press) begin
                    m_pend = 1'b1;
                    if (m_count < MAX) m_count = m_count + 1;
                end
            end
            // synchronized level seen at an edge is the sample from two edges earlier
            flip = 1'b1;
            for (int i = 1; i <= DEB; i++) if (hist[i] == m_stab) flip = 1'b0;
            m_stab_d = m_stab;
            if (flip) m_stab = !m_stab;
            for (int i = DEB; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = btn;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press();
        btn = 1'b1; tick(8);
        btn = 1'b0; tick(8);
    endtask

    task automatic serve();
        verde = 1'b1; tick(2);
        verde = 1'b0; tick(LOCK + 2);
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            check("cerere", 32'(cer), 32'(m_pend));
            check("asteptare", 32'(ast), 32'(m_pend));
            check("count", 32'(cnt), 32'(m_count));
        end
    end

    initial begin
        rst = 1'b1; en = 1'b1; svc = 1'b0; btn = 1'b0; verde = 1'b0;
        tick(3);
        rst = 1'b0;
        check("rst_cer", 32'(cer), 32'd0);
        check("rst_cnt", 32'(cnt), 32'd0);

        // clean press: request appears after the seventh edge
        btn = 1'b1; tick(6);
        check("t1_early", 32'(cer), 32'd0);
        tick(1);
        check("t1_cer", 32'(cer), 32'd1);
        check("t1_ast", 32'(ast), 32'd1);
        check("t1_cnt", 32'(cnt), 32'd1);
        tick(3); btn = 1'b0; tick(10);
        check("t1_hold", 32'(cer), 32'd1);

        // walk drops request; press landing during walk is ignored
        btn = 1'b1; tick(2);
        verde = 1'b1; tick(1);
        check("t3_drop", 32'(cer), 32'd0);
        tick(4); verde = 1'b0; btn = 1'b0; tick(30);
        check("t3_walk_cer", 32'(cer), 32'd0);
        check("t3_walk_cnt", 32'(cnt), 32'd1);
        // press inside lockout window ignored
        verde = 1'b1; tick(5);
        verde = 1'b0; press(); tick(4);
        check("t3_lock_cer", 32'(cer), 32'd0);
        check("t3_lock_cnt", 32'(cnt), 32'd1);
        press();
        check("t3_after_cer", 32'(cer), 32'd1);
        check("t3_after_cnt", 32'(cnt), 32'd2);

        // service clears and blocks requests
        svc = 1'b1; tick(1);
        check("t4_clear", 32'(cer), 32'd0);
        press();
        check("t4_blk_cer", 32'(cer), 32'd0);
        check("t4_blk_cnt", 32'(cnt), 32'd2);
        svc = 1'b0; press();
        check("t4_acc_cer", 32'(cer), 32'd1);
        check("t4_acc_cnt", 32'(cnt), 32'd3);

        // asynchronous reset mid-operation
        #2 rst = 1'b1;
        #1;
        check("t5_cer", 32'(cer), 32'd0);
        check("t5_ast", 32'(ast), 32'd0);
        check("t5_cnt", 32'(cnt), 32'd0);
        tick(2); rst = 1'b0;

        // bouncing button never debounces
        for (int i = 0; i < 6; i++) begin
            btn = (i % 2 == 0); tick(2);
        end
        btn = 1'b0; tick(10);
        check("t2_cer", 32'(cer), 32'd0);
        check("t2_cnt", 32'(cnt), 32'd0);

        // full latency again after reset
        btn = 1'b1; tick(6);
        check("t5_early", 32'(cer), 32'd0);
        tick(1);
        check("t5_lat", 32'(cer), 32'd1);
        tick(1); btn = 1'b0; tick(8);

        // randomized traffic, checked every cycle by the model compare
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) btn = ~btn;
            if ($urandom_range(0, 24) == 0) verde = ~verde;
            svc = ($urandom_range(0, 79) == 0);
            en  = ($urandom_range(0, 19) != 0);
            tick(1);
        end
        btn = 1'b0; verde = 1'b0; en = 1'b1; svc = 1'b1; tick(1);
        svc = 1'b0; tick(10);

        // saturation
        for (int i = 0; i < 260; i++) begin
            press(); serve();
        end
        press();
        check("t6_sat", 32'(cnt), 32'd255);
        check("t6_cer", 32'(cer), 32'd1);

        // disabled press is dropped and never replayed
        serve();
        en = 1'b0; press();
        en = 1'b1;
        check("t6_en_drop", 32'(cer), 32'd0);
        tick(10);
        check("t6_en_idle", 32'(cer), 32'd0);
        check("t6_en_cnt", 32'(cnt), 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
